// File: rtl/pipeline_fetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory, the redirect source and decode.
// The master modport is the fetch unit; the slave modport is its environment.
interface pipeline_fetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect, redirect_pc, dec_ready
  );
endinterface

// File: rtl/pipeline_fetch_queue.sv
// Instruction-fetch front end: sequential fetch, in-order {pc,inst} queue, redirect flush.
// Define FETCH_QUEUE_BYPASS_EN to let a response reach decode in its arrival cycle when the queue is empty.
module pipeline_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0040_0000
) (
  input  logic                          clock,
  input  logic                          reset,
  pipeline_fetch_queue_if.master        fq
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  ptr_t        head_q, head_d, tail_q, tail_d;
  cnt_t        count_q, count_d;
  cnt_t        inflight_q, inflight_d;
  cnt_t        drop_q, drop_d;
  entry_t      mem_q [DEPTH];

  logic        req_fire, resp_take, resp_keep, bypass, push, pop, queue_nonempty;
  logic [CW:0] credits_used;
  logic [31:0] redirect_target;
  entry_t      head_entry;

  assign redirect_target = {fq.redirect_pc[31:2], 2'b00};
  assign queue_nonempty  = (count_q != '0);
  assign head_entry      = mem_q[head_q];

  // Every outstanding request owns a queue slot, so a returning word always has room.
  assign credits_used      = {1'b0, count_q} + {1'b0, inflight_q};
  assign fq.imem_req_valid = !reset && !fq.redirect && (credits_used < (CW+1)'(DEPTH));
  assign fq.imem_req_addr  = fetch_pc_q;
  assign req_fire          = fq.imem_req_valid && fq.imem_req_ready;

  // A response with nothing in flight is a leftover from before a reset and is ignored.
  assign resp_take = !reset && fq.imem_resp_valid && (inflight_q != '0);
  assign resp_keep = resp_take && (drop_q == '0) && !fq.redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = resp_keep && !queue_nonempty;
`else
  assign bypass = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    fq.dec_valid = 1'b0;
    fq.dec_pc    = '0;
    fq.dec_inst  = '0;
    if (!reset) begin
      if (queue_nonempty) begin
        fq.dec_valid = 1'b1;
        fq.dec_pc    = head_entry.pc;
        fq.dec_inst  = head_entry.inst;
      end else if (bypass) begin
        fq.dec_valid = 1'b1;
        fq.dec_pc    = resp_pc_q;
        fq.dec_inst  = fq.imem_resp_data;
      end
    end
  end

  assign pop  = queue_nonempty && fq.dec_valid && fq.dec_ready;
  assign push = resp_keep && !(bypass && fq.dec_ready);

  // resp_pc tracks the address of the next surviving response; requests are strictly sequential.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + cnt_t'(req_fire) - cnt_t'(resp_take);
    if (fq.redirect) begin
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      drop_d     = inflight_d;
    end else begin
      if (req_fire)                     fetch_pc_d = fetch_pc_q + 32'd4;
      if (resp_keep)                    resp_pc_d  = resp_pc_q + 32'd4;
      if (resp_take && drop_q != '0)    drop_d     = drop_q - cnt_t'(1);
      if (push)                         tail_d     = tail_q + ptr_t'(1);
      if (pop)                          head_d     = head_q + ptr_t'(1);
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= PC_RESET;
      resp_pc_q  <= PC_RESET;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // NOTE: queue storage has no reset; count and head gate every read so stale contents are never seen.
  always_ff @(posedge clock) begin
    if (push) mem_q[tail_q] <= '{pc: resp_pc_q, inst: fq.imem_resp_data};
  end

  push_never_full: assert property (@(posedge clock) disable iff (reset)
    push |-> (count_q < cnt_t'(DEPTH)))
    else $error("fetch queue push while full");

  drop_within_inflight: assert property (@(posedge clock) disable iff (reset)
    !(drop_q > inflight_q))
    else $error("fetch queue drop count exceeds in-flight count");

  inflight_bounded: assert property (@(posedge clock) disable iff (reset)
    !(inflight_q > cnt_t'(DEPTH)))
    else $error("fetch queue in-flight count exceeds depth");
endmodule

// File: tb/tb_pipeline_fetch_queue.sv
// Scoreboard bench for pipeline_fetch_queue: directed scenarios, then randomized traffic
// against an in-order memory model and a sequential-pc expectation queue.
module tb_pipeline_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] PC_RESET = 32'h0040_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int RESP_TO_DEC = 0;
`else
  localparam int RESP_TO_DEC = 1;
`endif

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pipeline_fetch_queue_if fq ();

  pipeline_fetch_queue #(.DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
    .clock (clock),
    .reset (reset),
    .fq    (fq.master)
  );

  int          n_vec = 0;
  int          n_miss = 0;
  int          cycle = 0;
  int          lat_lo = 1, lat_hi = 1;
  int          req_fires = 0;
  int          first_resp_cycle = -1;
  int          first_dec_cycle = -1;
  logic        last_req_valid;
  logic [31:0] exp_req_pc = PC_RESET;
  exp_t        exp_q[$];
  pend_t       pend_q[$];
  logic [31:0] req_log[$];
  logic [31:0] dec_pc_log[$];
  int          dec_cycle_log[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // One clock cycle: drive inputs, play memory, sample at negedge, update the model after the edge.
  task automatic step(input bit rdy, input bit drdy, input bit rst,
                      input bit redir = 1'b0, input logic [31:0] rpc = 32'h0);
    reset             = rst;
    fq.imem_req_ready = rdy;
    fq.dec_ready      = drdy;
    fq.redirect       = redir;
    fq.redirect_pc    = rpc;
    if (pend_q.size() != 0 && pend_q[0].due <= cycle) begin
      fq.imem_resp_valid = 1'b1;
      fq.imem_resp_data  = inst_of(pend_q[0].addr);
      void'(pend_q.pop_front());
      if (first_resp_cycle < 0) first_resp_cycle = cycle;
    end else begin
      fq.imem_resp_valid = 1'b0;
      fq.imem_resp_data  = $urandom();
    end
    @(negedge clock);
    last_req_valid = fq.imem_req_valid;
    if (rst || redir) check("req_valid_blocked", {31'b0, fq.imem_req_valid}, 32'd0);
    if (rst)          check("dec_valid_in_reset", {31'b0, fq.dec_valid}, 32'd0);
    if (fq.imem_req_valid && rdy) begin
      check("req_addr", fq.imem_req_addr, exp_req_pc);
      exp_q.push_back('{pc: exp_req_pc, inst: inst_of(exp_req_pc)});
      pend_q.push_back('{addr: fq.imem_req_addr, due: cycle + int'($urandom_range(lat_hi, lat_lo))});
      req_log.push_back(fq.imem_req_addr);
      exp_req_pc = exp_req_pc + 32'd4;
      req_fires++;
    end
    @(posedge clock);
    cycle++;
    if (rst) begin
      exp_q.delete();
      exp_req_pc = PC_RESET;
    end else if (redir) begin
      exp_q.delete();
      exp_req_pc = rpc & ~32'd3;
    end
    #1;
  endtask

  // Monitor: every decode transfer must match the head of the expectation queue.
  initial forever begin
    @(negedge clock);
    if (fq.dec_valid === 1'b1 && first_dec_cycle < 0) first_dec_cycle = cycle;
    if (fq.dec_valid === 1'b1 && fq.dec_ready === 1'b1) begin
      dec_pc_log.push_back(fq.dec_pc);
      dec_cycle_log.push_back(cycle);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL dec_unexpected: got transfer pc %h, expected no transfer (cycle %0d)",
                 fq.dec_pc, cycle);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("dec_pc", fq.dec_pc, e.pc);
        check("dec_inst", fq.dec_inst, e.inst);
      end
    end else if (fq.dec_valid === 1'b0) begin
      check("dec_idle_zero", fq.dec_pc | fq.dec_inst, 32'd0);
    end
  end

  task automatic drain();
    for (int i = 0; i < 300 && (pend_q.size() != 0 || exp_q.size() != 0); i++) step(1'b0, 1'b1, 1'b0);
    check("drain_leftover", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    req_log.delete();
    dec_pc_log.delete();
    dec_cycle_log.delete();
    req_fires        = 0;
    first_resp_cycle = -1;
    first_dec_cycle  = -1;
  endtask

  initial begin
    fq.imem_req_ready  = 1'b0;
    fq.imem_resp_valid = 1'b0;
    fq.imem_resp_data  = '0;
    fq.redirect        = 1'b0;
    fq.redirect_pc     = '0;
    fq.dec_ready       = 1'b0;

    // Streaming after reset: sequential pcs, fixed response-to-decode latency, no gaps.
    do_reset(3);
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);
    check("first_req_addr", req_log.size() > 0 ? req_log[0] : 32'hDEAD_BEEF, PC_RESET);
    check("resp_to_dec_latency", 32'(first_dec_cycle - first_resp_cycle), 32'(RESP_TO_DEC));
    check("stream_len_ge8", {31'b0, dec_cycle_log.size() >= 8}, 32'd1);
    if (dec_cycle_log.size() >= 8) begin
      check("stream_no_gaps", 32'(dec_cycle_log[7] - dec_cycle_log[0]), 32'd7);
      check("stream_pc7", dec_pc_log[7], PC_RESET + 32'h1C);
    end
    drain();

    // Decode stalled: credits stop fetch at DEPTH, one pop frees exactly one request.
    do_reset(2);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    check("stall_fires", 32'(req_fires), 32'(DEPTH));
    check("stall_req_valid", {31'b0, last_req_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    check("one_pop_one_req", 32'(req_fires), 32'(DEPTH + 1));
    drain();

    // Redirect with two requests in flight: both words dropped, restart at the aligned target.
    do_reset(2);
    lat_lo = 3; lat_hi = 3;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("redir_inflight_fires", 32'(req_fires), 32'd2);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0002);
    req_log.delete();
    dec_pc_log.delete();
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
    check("redir_next_req", req_log.size() > 0 ? req_log[0] : 32'hDEAD_BEEF, 32'h8000_0000);
    check("redir_first_dec", dec_pc_log.size() > 0 ? dec_pc_log[0] : 32'hDEAD_BEEF, 32'h8000_0000);
    drain();

    // Redirect near the top of the address space: fetch pc wraps to zero.
    do_reset(2);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    check("wrap_req0", req_log.size() > 1 ? req_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check("wrap_req1", req_log.size() > 1 ? req_log[1] : 32'hDEAD_BEEF, 32'h0000_0000);
    drain();

    // Reset with three requests in flight: late responses are ignored, fetch restarts at PC_RESET.
    do_reset(2);
    lat_lo = 4; lat_hi = 4;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    check("rst_inflight_fires", 32'(req_fires), 32'd3);
    do_reset(1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
    check("stale_no_dec", 32'(dec_pc_log.size()), 32'd0);
    check("stale_first_dec_seen", first_dec_cycle < 0 ? 32'd0 : 32'd1, 32'd0);
    lat_lo = 1; lat_hi = 2;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
    check("post_rst_req", req_log.size() > 0 ? req_log[0] : 32'hDEAD_BEEF, PC_RESET);
    drain();

    // Randomized traffic: ready, latency, decode back-pressure and redirects all vary.
    do_reset(2);
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 60, 1'b0,
           $urandom_range(0, 99) < 3, $urandom());
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
